beat_note_scheduler: RTL and testbench
======================================

// Module: beat_note_scheduler
// PURPOSE
//  Gameplay sequencer. Runs while the top FSM is in GAMEPLAY (enable high).
//  Generates the beat clock from the BPM of the selected song and walks that song's note-pattern ROM.
//  Emits one lane-spawn word per beat, filtered by difficulty, to the arrow renderer.
//  Pulses game_over when the song ends, which returns the top FSM to SONG_SELECTOR.
// PARAMETERS
//  CLK_HZ    50_000_000  clock frequency; beat threshold TH = CLK_HZ*60
//  SONG_LEN  64          number of pattern beats per song (1..2**ADDR_W)
//  ADDR_W    6           pattern ROM address width
//  LEAD_IN   4           silent count-in beats before pattern beat 0
// PORTS
//  clk           in   1       system clock
//  rst           in   1       synchronous, active-high reset
//  enable        in   1       high only while top FSM is in GAMEPLAY
//  start         in   1       1-cycle pulse: begin song
//  pause         in   1       level: freeze beat accumulator and FSM
//  difficulty    in   2       0 easy, 1 normal, 2/3 hard
//  bpm           in   8       song tempo, sampled at start
//  pattern_addr  out  ADDR_W  pattern ROM address
//  pattern_data  in   4       ROM word {up,down,left,right}, valid 1 cycle after addr
//  beat_tick     out  1       1-cycle pulse per beat (lead-in included)
//  spawn_valid   out  1       1-cycle pulse: spawn_lanes valid
//  spawn_lanes   out  4       lanes to spawn
//  beat_count    out  ADDR_W  index of the current pattern beat
//  busy          out  1       high in LEAD, PLAY
//  game_over     out  1       1-cycle pulse at song end
// BEHAVIOUR
//  Reset: FSM=IDLE; all outputs 0; accumulator 0; latched bpm/difficulty 0.
//  States: IDLE -> LEAD -> PLAY -> DONE -> IDLE.
//  IDLE: start & enable & bpm!=0 -> latch bpm and difficulty, acc=0, addr=0, lead count=0 -> LEAD.
//   start with bpm==0 or enable low is ignored.
//  Beat generator (LEAD/PLAY, pause low): acc <= acc + bpm_l.
//   If acc + bpm_l >= TH: acc <= acc + bpm_l - TH and beat_tick=1 that cycle.
//   acc is 32 bits, so no overflow.
//  Pause high: acc, FSM, counters and addr hold; no ticks or spawns.
//  LEAD: counts LEAD_IN ticks with no spawns. On the LEAD_IN-th tick -> PLAY.
//   pattern_addr is held at 0 throughout, so data is prefetched.
//  PLAY, on each tick:
//   - Register the prefetched pattern_data as the candidate word.
//   - Next cycle, spawn_valid = (filtered word != 0) and spawn_lanes = filtered word.
//   - Tick-to-spawn latency is 1 cycle.
//   - On the tick cycle, beat_count is incremented and pattern_addr <= beat_count+1.
//     ROM data is therefore stable well before the next tick (period >= 2 cycles required).
//  Filter:
//   - diff 0: spawn only on even beat_count, lanes reduced to the lowest set bit.
//   - diff 1: all beats, at most 2 lanes (lowest two set bits).
//   - diff 2/3: unfiltered.
//  Word 4'b0000 is a rest: spawn_valid stays 0 and beat_tick still pulses.
//  End: the tick that consumes beat SONG_LEN-1 still spawns. The next cycle enters DONE.
//  DONE: game_over=1 for exactly 1 cycle; busy=0 -> IDLE.
//   pattern_addr returns to 0; beat_count holds its final value until the next start.
//  Abort: enable low in any non-IDLE state -> IDLE next cycle.
//   No game_over; spawn/tick outputs forced 0 that cycle.
//  start while busy: ignored. rst mid-song: full reset, no game_over.
// TESTING  (CLK_HZ=60 so TH=3600; bpm=120 -> 30 cycles/beat; SONG_LEN=4; LEAD_IN=4)
//  1. Reset, then diff=2, ROM={1,2,4,8}, start@t0.
//     -> beat_tick at t0+30k; spawns 1,2,4,8 one cycle after ticks 5..8.
//     -> game_over 1 cycle after tick 8; busy falls with it.
//  2. diff=0, ROM={3,F,6,0}.
//     -> spawns 1 (beat0) and 2 (beat2) only; beats 1 and 3 give no spawn_valid.
//  3. diff=1, ROM={F,7,0,9}.
//     -> spawns 3, 3, none, 9; beat 2 still produces beat_tick.
//  4. pause held 45 cycles mid-PLAY.
//     -> tick spacing across the pause = 30+45; no tick or spawn while paused.
//  5. enable dropped in PLAY after 2 spawns.
//     -> IDLE next cycle, no game_over; a new start replays from beat 0 with lead-in.
//  6. start with bpm=0 -> stays IDLE, busy=0.
//     bpm=255 -> ticks at intervals of 14 or 15 cycles (avg 14.12).

Source files
------------

// File: rtl/beat_note_scheduler.sv
`default_nettype none
// beat_note_scheduler: BPM beat clock and note-pattern walker that emits
// difficulty-filtered lane-spawn words during gameplay.   rev 1.0
module beat_note_scheduler #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int SONG_LEN = 64,
  parameter int ADDR_W   = 6,
  parameter int LEAD_IN  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              start,
  input  logic              pause,
  input  logic [1:0]        difficulty,
  input  logic [7:0]        bpm,
  output logic [ADDR_W-1:0] pattern_addr,
  input  logic [3:0]        pattern_data,
  output logic              beat_tick,
  output logic              spawn_valid,
  output logic [3:0]        spawn_lanes,
  output logic [ADDR_W-1:0] beat_count,
  output logic              busy,
  output logic              game_over
);

  // CLK_HZ*60 exceeds the int range at 50 MHz, so it is formed in 64 bits.
  localparam longint          TH64      = longint'(CLK_HZ) * 64'sd60;
  localparam logic [31:0]     TH        = 32'(TH64);
  localparam int              LC_W      = $clog2(LEAD_IN + 1);
  localparam logic [LC_W-1:0] LEAD_LAST = LC_W'(LEAD_IN - 1);
  localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(SONG_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LEAD = 2'd1,
    S_PLAY = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [31:0]       r_acc;
  logic [7:0]        r_bpm;
  logic [1:0]        r_diff;
  logic [LC_W-1:0]   r_lead_cnt;
  logic              r_spawn;
  logic [3:0]        r_lanes;

  logic              w_start;
  logic              w_run;
  logic [31:0]       w_sum;
  logic              w_tick;
  logic [3:0]        w_filt;

  function automatic logic [3:0] lane_filter(input logic [3:0] w,
                                             input logic [1:0] d,
                                             input logic       even);
    logic [3:0] lo1;
    logic [3:0] rest;
    logic [3:0] lo2;
    lo1  = w & (~w + 4'd1);
    rest = w & ~lo1;
    lo2  = rest & (~rest + 4'd1);
    case (d)
      2'd0:    lane_filter = even ? lo1 : 4'd0;
      2'd1:    lane_filter = lo1 | lo2;
      default: lane_filter = w;
    endcase
  endfunction

  assign w_start = start && enable && (bpm != 8'd0);
  assign w_run   = enable && !pause && ((state == S_LEAD) || (state == S_PLAY));
  assign w_sum   = r_acc + {24'd0, r_bpm};
  assign w_tick  = w_run && (w_sum >= TH);
  assign w_filt  = lane_filter(pattern_data, r_diff, ~beat_count[0]);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    beat_tick   = w_tick;
    busy        = (state == S_LEAD) || (state == S_PLAY);
    game_over   = (state == S_DONE) && enable && !pause;
    spawn_valid = r_spawn && enable && !pause;
    spawn_lanes = 4'd0;
    if (spawn_valid) spawn_lanes = r_lanes;
    if ((state != S_IDLE) && !enable) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (w_start) state_nxt = S_LEAD;
        S_LEAD:  if (w_tick && (r_lead_cnt == LEAD_LAST)) state_nxt = S_PLAY;
        S_PLAY:  if (w_tick && (beat_count == LAST_BEAT)) state_nxt = S_DONE;
        S_DONE:  if (!pause) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc        <= 32'd0;
      r_bpm        <= 8'd0;
      r_diff       <= 2'd0;
      r_lead_cnt   <= '0;
      r_spawn      <= 1'b0;
      r_lanes      <= 4'd0;
      pattern_addr <= '0;
      beat_count   <= '0;
    end else begin
      if ((state == S_IDLE) && w_start) begin
        r_bpm        <= bpm;
        r_diff       <= difficulty;
        r_acc        <= 32'd0;
        r_lead_cnt   <= '0;
        pattern_addr <= '0;
        beat_count   <= '0;
      end
      // A pending spawn survives a pause and is presented once it lifts.
      if (!enable || !pause) r_spawn <= 1'b0;
      if (w_run) begin
        r_acc <= w_tick ? (w_sum - TH) : w_sum;
        if (w_tick && (state == S_LEAD)) r_lead_cnt <= r_lead_cnt + LC_W'(1);
        if (w_tick && (state == S_PLAY)) begin
          r_spawn <= (w_filt != 4'd0);
          r_lanes <= w_filt;
          if (beat_count == LAST_BEAT) begin
            pattern_addr <= '0;
          end else begin
            beat_count   <= beat_count + ADDR_W'(1);
            pattern_addr <= beat_count + ADDR_W'(1);
          end
        end
      end
      if ((state != S_IDLE) && !enable) pattern_addr <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_beat_note_scheduler.sv
`default_nettype none
// tb_beat_note_scheduler: directed vectors and corner sequences for
// beat_note_scheduler (TH=3600, SONG_LEN=4, LEAD_IN=4).   rev 1.0
module tb_beat_note_scheduler;

  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic              start;
  logic              pause;
  logic [1:0]        difficulty;
  logic [7:0]        bpm;
  logic [ADDR_W-1:0] pattern_addr;
  logic [3:0]        pattern_data = 4'd0;
  logic              beat_tick;
  logic              spawn_valid;
  logic [3:0]        spawn_lanes;
  logic [ADDR_W-1:0] beat_count;
  logic              busy;
  logic              game_over;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [3:0] rom [4];

  typedef struct packed {
    logic [1:0]  diff;
    logic [15:0] rom;   // nibble i = ROM word of beat i
    logic [15:0] exp;   // nibble i = expected lanes, 0 = no spawn
  } vec_t;

  vec_t vecs [6];

  beat_note_scheduler #(
    .CLK_HZ(60), .SONG_LEN(4), .ADDR_W(ADDR_W), .LEAD_IN(4)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .pause(pause),
    .difficulty(difficulty), .bpm(bpm), .pattern_addr(pattern_addr),
    .pattern_data(pattern_data), .beat_tick(beat_tick),
    .spawn_valid(spawn_valid), .spawn_lanes(spawn_lanes),
    .beat_count(beat_count), .busy(busy), .game_over(game_over)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) pattern_data <= rom[pattern_addr[1:0]];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Tick k lands on the first active cycle n with n*bpm >= k*3600.
  function automatic int exp_tick(input int k, input int b);
    return (3600 * k + b - 1) / b;
  endfunction

  task automatic pulse_start(output int t0);
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_tick(output int c);
    c = -1;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (beat_tick) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) check("tick_timeout", 0, 1);
  endtask

  task automatic run_song(input vec_t v, input logic [7:0] b);
    int t0, nt, last_tick, stray;
    logic done;
    logic seen [4];
    logic [3:0] got [4];
    for (int i = 0; i < 4; i++) begin
      rom[i]  = v.rom[4*i +: 4];
      seen[i] = 1'b0;
      got[i]  = 4'd0;
    end
    difficulty = v.diff;
    bpm = b;
    pulse_start(t0);
    nt = 0; last_tick = -10; stray = 0; done = 1'b0;
    for (int n = 0; n < 2000 && !done; n++) begin
      if (spawn_valid) begin
        if (nt >= 5 && nt <= 8 && cyc == last_tick + 1) begin
          seen[nt-5] = 1'b1;
          got[nt-5]  = spawn_lanes;
        end else begin
          stray++;
        end
      end
      if (beat_tick) begin
        nt++;
        last_tick = cyc;
        check("tick_time", cyc - t0, exp_tick(nt, int'(b)));
      end
      if (game_over) begin
        done = 1'b1;
        check("game_over_time", cyc - t0, exp_tick(8, int'(b)) + 1);
        check("busy_at_game_over", int'(busy), 0);
      end
      if (!done) @(negedge clk);
    end
    check("song_completed", int'(done), 1);
    check("tick_count", nt, 8);
    check("stray_spawns", stray, 0);
    for (int i = 0; i < 4; i++) begin
      check("spawn_valid_beat", int'(seen[i]), int'(v.exp[4*i +: 4] != 4'd0));
      check("spawn_lanes_beat", int'(got[i]), int'(v.exp[4*i +: 4]));
    end
    @(negedge clk);
    check("addr_after_done", int'(pattern_addr), 0);
    check("game_over_one_cycle", int'(game_over), 0);
  endtask

  initial begin
    int t0, t5, t6, tn, bad;
    vecs[0] = '{diff: 2'd2, rom: 16'h8421, exp: 16'h8421};
    vecs[1] = '{diff: 2'd0, rom: 16'h06F3, exp: 16'h0201};
    vecs[2] = '{diff: 2'd1, rom: 16'h907F, exp: 16'h9033};
    vecs[3] = '{diff: 2'd3, rom: 16'hFA50, exp: 16'hFA50};
    vecs[4] = '{diff: 2'd1, rom: 16'h61C8, exp: 16'h61C8};
    vecs[5] = '{diff: 2'd0, rom: 16'h90CC, exp: 16'h0004};
    for (int i = 0; i < 4; i++) rom[i] = 4'd0;

    rst = 1'b1; enable = 1'b1; start = 1'b0; pause = 1'b0;
    difficulty = 2'd0; bpm = 8'd120;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          int'({busy, beat_tick, spawn_valid, spawn_lanes, game_over}), 0);
    check("reset_addr_count", int'({pattern_addr, beat_count}), 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_song(vecs[i], 8'd120);

    // Pause of 45 cycles between ticks 5 and 6 stretches that gap to 75.
    for (int i = 0; i < 4; i++) rom[i] = vecs[0].rom[4*i +: 4];
    difficulty = 2'd2; bpm = 8'd120;
    pulse_start(t0);
    for (int k = 0; k < 5; k++) wait_tick(t5);
    check("pause_tick5_time", t5 - t0, 150);
    repeat (5) @(negedge clk);
    pause = 1'b1; bad = 0;
    repeat (45) begin
      @(negedge clk);
      if (beat_tick || spawn_valid) bad++;
    end
    pause = 1'b0;
    check("pause_no_events", bad, 0);
    wait_tick(tn);
    check("pause_tick_gap", tn - t5, 75);
    bad = -1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (game_over) begin bad = cyc - t0; break; end
    end
    check("pause_game_over_time", bad, 241 + 45);

    // Abort by dropping enable after the second spawn, then replay.
    pulse_start(t0);
    for (int k = 0; k < 6; k++) wait_tick(t6);
    @(negedge clk);
    check("abort_second_spawn", int'({spawn_valid, spawn_lanes}), 5'h12);
    enable = 1'b0;
    @(negedge clk);
    check("abort_idle", int'({busy, beat_tick, spawn_valid}), 0);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (game_over || busy) bad++;
    end
    check("abort_no_game_over", bad, 0);
    enable = 1'b1;
    run_song(vecs[0], 8'd120);

    // start is ignored with bpm==0 or enable low.
    bpm = 8'd0;
    pulse_start(t0);
    bad = 0;
    repeat (40) begin @(negedge clk); if (busy || beat_tick) bad++; end
    check("bpm_zero_idle", bad, 0);
    bpm = 8'd120; enable = 1'b0;
    pulse_start(t0);
    bad = 0;
    repeat (40) begin @(negedge clk); if (busy || beat_tick) bad++; end
    check("disabled_start_idle", bad, 0);
    enable = 1'b1;

    // Reset mid-song clears everything without a game_over.
    pulse_start(t0);
    repeat (60) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midsong_reset_outputs", int'({busy, beat_count, pattern_addr}), 0);
    bad = 0;
    repeat (300) begin @(negedge clk); if (game_over || beat_tick) bad++; end
    check("midsong_reset_quiet", bad, 0);

    // bpm=255: non-integer period, ticks 14 or 15 cycles apart.
    run_song(vecs[3], 8'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
